rom_quad_arbiter: RTL and testbench
===================================

# rom_quad_arbiter

Shares a single synchronous image-ROM read port between two requesters: the VGA pixel reader (single reads, strict priority) and the resizer's 2x2 neighbourhood fetch (quad reads of p0..p3, issued sequentially). It replaces the four parallel ROM copies feeding the resizer with one port plus this scheduler. It sits between the ROM instance, the resizer datapath and the VGA address generator, all in the 50 MHz domain.

## Interface
- IMG_WIDTH, 160, source image width in pixels
- IMG_HEIGHT, 120, source image height in pixels
- ADDR_W, 15, ROM address width
- DATA_W, 8, pixel width
- X_W, 8, quad x coordinate width
- Y_W, 7, quad y coordinate width

- clk  in  1  system clock (CLOCK_50); all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- vga_req  in  1  VGA read request, sampled each cycle
- vga_addr  in  ADDR_W  VGA read address, valid with vga_req
- vga_valid  out  1  one-cycle pulse, vga_data valid
- vga_data  out  DATA_W  VGA read result, held until the next vga_valid
- quad_req  in  1  quad fetch request; held high until quad_ack
- quad_x  in  X_W  column of p0
- quad_y  in  Y_W  row of p0
- quad_ack  out  1  request accepted this cycle (combinational: IDLE && quad_req)
- quad_valid  out  1  one-cycle pulse, p0..p3 valid
- quad_p0..quad_p3  out  DATA_W each  (x,y), (x+1,y), (x,y+1), (x+1,y+1)
- busy  out  1  high in every state except IDLE
- rom_addr  out  ADDR_W  address to ROM port
- rom_q  in  DATA_W  ROM data, valid one cycle after rom_addr

## Operation
- FSM: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: on quad_req, assert quad_ack, latch base = quad_y*IMG_WIDTH + quad_x (ADDR_W bits, truncated), clear idx, go to ISSUE. Requests in other states are ignored (not acked).
- ISSUE: each cycle without vga_req, drive the neighbour address for idx, tag it (QUAD, idx), increment idx; after idx 3 is issued go to DRAIN.
- Any cycle with vga_req (any state): rom_addr = vga_addr, tag (VGA); quad issue stalls that cycle, idx unchanged.
- Neighbour offsets: 0, +1, +IMG_WIDTH, +IMG_WIDTH+1, computed modulo 2^ADDR_W.
- Return path: one-stage tag register. When the tag is QUAD, rom_q is written to quad_p[idx]; when VGA, rom_q is registered into vga_data with vga_valid pulsed.
- DRAIN: wait for the idx-3 return to be captured, then go to DONE.
- DONE: quad_valid = 1 for one cycle, then IDLE. quad_p0..p3 hold until overwritten by the next fetch.
- No cycle with neither requester active: rom_addr = 0, tag = none.
- Coordinates are not range-checked. Out-of-range x/y produce truncated addresses with no error.
- Continuous vga_req starves the quad indefinitely. This is by design, because the 25 MHz pixel clock requests at most every second cycle.
- Reset (async, any state): FSM to IDLE, in-flight tags discarded, all outputs 0: rom_addr, vga_valid, vga_data, quad_valid, quad_p0..p3, busy, quad_ack.

## Timing
- VGA: vga_req in cycle N -> vga_valid and vga_data in N+2, fixed regardless of quad activity.
- Quad, no contention: ack in T; issues in T+1..T+4; p3 returns in T+5; quad_valid in T+6.
- Each vga_req cycle inside T+1..T+4 delays quad_valid by exactly one cycle.
- Earliest next quad_ack is T+7 (IDLE re-entered after DONE).
- A vga_req in the same cycle as quad_ack is served. The quad's first issue still starts the following cycle.

## Configuration
- QUAD_EDGE_CLAMP_EN defined:
  - if quad_x == IMG_WIDTH-1, p1/p3 use column x;
  - if quad_y == IMG_HEIGHT-1, p2/p3 use row y;
  - edge pixels are replicated and no read leaves the image.
- Undefined: raw offsets with modulo-2^ADDR_W wrap. This matches the legacy four-ROM addressing.

## Test plan
- Reset mid-fetch: assert reset in T+3 -> busy, quad_valid, quad_p*, vga_valid all 0. Next quad_req is acked immediately after release.
- Quad alone: x=5, y=2, ROM = addr&0xFF -> rom_addr 325, 326, 485, 486 in T+1..T+4. quad_valid in T+6 with p0..p3 = 0x45, 0x46, 0xE5, 0xE6.
- VGA interleave: vga_req on alternate cycles during the quad -> every vga_valid is exactly 2 cycles after its request with correct data. quad_valid arrives late by the number of VGA cycles in the issue window, and p0..p3 are unchanged.
- Busy rejection: quad_req held through a fetch -> single ack in T, second ack in T+7, never while busy.
- Edge, macro defined: x=159, y=119 -> all four reads at address 19199. Macro undefined: addresses 19199, 19200, 19359, 19360.

Source files
------------

// File: rtl/rom_quad_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rom_quad_arbiter
//  Purpose  : Shares one synchronous image-ROM read port between the VGA pixel
//             reader (single reads, strict priority) and the resizer's 2x2
//             neighbourhood fetch (four sequential reads p0..p3).
//  Options  : define QUAD_EDGE_CLAMP_EN to replicate right/bottom edge pixels
//             instead of wrapping the neighbour addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module rom_quad_arbiter #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int X_W        = 8,
    parameter int Y_W        = 7
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_valid,
    output logic [DATA_W-1:0] vga_data,

    input  logic              quad_req,
    input  logic [X_W-1:0]    quad_x,
    input  logic [Y_W-1:0]    quad_y,
    output logic              quad_ack,
    output logic              quad_valid,
    output logic [DATA_W-1:0] quad_p0,
    output logic [DATA_W-1:0] quad_p1,
    output logic [DATA_W-1:0] quad_p2,
    output logic [DATA_W-1:0] quad_p3,
    output logic              busy,

    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] c_ONE        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_ROW_STRIDE = ADDR_W'(IMG_WIDTH);
    localparam logic [X_W-1:0]    c_LAST_COL   = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0]    c_LAST_ROW   = Y_W'(IMG_HEIGHT - 1);
`ifdef QUAD_EDGE_CLAMP_EN
    localparam bit                c_CLAMP      = 1'b1;
`else
    localparam bit                c_CLAMP      = 1'b0;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [1:0]          r_idx;
    logic                r_clamp_x;
    logic                r_clamp_y;
    logic                r_tag_vga;
    logic                r_tag_quad;
    logic [1:0]          r_tag_idx;
    logic                r_vga_valid;
    logic [DATA_W-1:0]   r_vga_data;

    logic                w_accept;
    logic                w_issue;
    logic                w_at_right;
    logic                w_at_bottom;
    logic [ADDR_W-1:0]   w_base_nxt;
    logic [ADDR_W-1:0]   w_step_x;
    logic [ADDR_W-1:0]   w_step_y;
    logic [ADDR_W-1:0]   w_nbr_addr;
    logic [ADDR_W-1:0]   w_rom_addr;

    // Fetch acceptance and quad issue; a VGA request always wins the port.
    assign w_accept    = (r_state == S_IDLE) && quad_req;
    assign w_issue     = (r_state == S_ISSUE) && !vga_req;

    assign w_base_nxt  = ADDR_W'(quad_y) * c_ROW_STRIDE + ADDR_W'(quad_x);
    assign w_at_right  = c_CLAMP && (quad_x == c_LAST_COL);
    assign w_at_bottom = c_CLAMP && (quad_y == c_LAST_ROW);

    assign w_step_x    = r_clamp_x ? '0 : c_ONE;
    assign w_step_y    = r_clamp_y ? '0 : c_ROW_STRIDE;

    always_comb begin
        w_nbr_addr = r_base;
        case (r_idx)
            2'd0:    w_nbr_addr = r_base;
            2'd1:    w_nbr_addr = r_base + w_step_x;
            2'd2:    w_nbr_addr = r_base + w_step_y;
            default: w_nbr_addr = r_base + w_step_x + w_step_y;
        endcase
    end

    always_comb begin
        w_rom_addr = '0;
        if (vga_req) begin
            w_rom_addr = vga_addr;
        end else if (w_issue) begin
            w_rom_addr = w_nbr_addr;
        end
    end

    // Reset forces the combinational outputs low as well as the registers.
    assign rom_addr   = reset ? '0 : w_rom_addr;
    assign quad_ack   = !reset && w_accept;
    assign quad_valid = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign vga_valid  = r_vga_valid;
    assign vga_data   = r_vga_data;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (quad_req) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_issue && (r_idx == 2'd3)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_tag_quad && (r_tag_idx == 2'd3)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base    <= '0;
            r_idx     <= 2'd0;
            r_clamp_x <= 1'b0;
            r_clamp_y <= 1'b0;
        end else if (w_accept) begin
            r_base    <= w_base_nxt;
            r_idx     <= 2'd0;
            r_clamp_x <= w_at_right;
            r_clamp_y <= w_at_bottom;
        end else if (w_issue) begin
            r_idx     <= r_idx + 2'd1;
        end
    end

    // Single-stage return tag, aligned with the ROM's one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_vga  <= 1'b0;
            r_tag_quad <= 1'b0;
            r_tag_idx  <= 2'd0;
        end else begin
            r_tag_vga  <= vga_req;
            r_tag_quad <= w_issue;
            if (w_issue) begin
                r_tag_idx <= r_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vga_valid <= 1'b0;
            r_vga_data  <= '0;
        end else begin
            r_vga_valid <= r_tag_vga;
            if (r_tag_vga) begin
                r_vga_data <= rom_q;
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_quad_pix
        logic r_pix;
        logic [DATA_W-1:0] r_pix_data;
        assign r_pix = r_tag_quad && (r_tag_idx == 2'(gi));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_pix_data <= '0;
            end else if (r_pix) begin
                r_pix_data <= rom_q;
            end
        end
    end

    assign quad_p0 = g_quad_pix[0].r_pix_data;
    assign quad_p1 = g_quad_pix[1].r_pix_data;
    assign quad_p2 = g_quad_pix[2].r_pix_data;
    assign quad_p3 = g_quad_pix[3].r_pix_data;

endmodule
`default_nettype wire

// File: tb/tb_rom_quad_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_quad_arbiter
//  Purpose  : Directed scoreboard bench for rom_quad_arbiter with a ROM model
//             returning addr[7:0] one cycle after the address.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_quad_arbiter;

    localparam int IMG_WIDTH = 160;

    typedef struct {
        int         due;
        logic [7:0] d;
    } vexp_t;

    typedef struct {
        int          due;
        logic [31:0] p;
    } qexp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_req;
    logic [14:0] vga_addr;
    logic        vga_valid;
    logic [7:0]  vga_data;
    logic        quad_req;
    logic [7:0]  quad_x;
    logic [6:0]  quad_y;
    logic        quad_ack;
    logic        quad_valid;
    logic [7:0]  quad_p0;
    logic [7:0]  quad_p1;
    logic [7:0]  quad_p2;
    logic [7:0]  quad_p3;
    logic        busy;
    logic [14:0] rom_addr;
    logic [7:0]  rom_q = 8'h00;

    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    vexp_t vq[$];
    qexp_t qq[$];

    rom_quad_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_valid  (vga_valid),
        .vga_data   (vga_data),
        .quad_req   (quad_req),
        .quad_x     (quad_x),
        .quad_y     (quad_y),
        .quad_ack   (quad_ack),
        .quad_valid (quad_valid),
        .quad_p0    (quad_p0),
        .quad_p1    (quad_p1),
        .quad_p2    (quad_p2),
        .quad_p3    (quad_p3),
        .busy       (busy),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rom_q <= rom_addr[7:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] nb(input int x, input int y, input int i);
        int dx;
        int dy;
        dx = i & 1;
        dy = (i >> 1) & 1;
`ifdef QUAD_EDGE_CLAMP_EN
        if (x == IMG_WIDTH - 1) dx = 0;
        if (y == 119) dy = 0;
`endif
        return 15'((y * IMG_WIDTH + x + dy * IMG_WIDTH + dx) % 32768);
    endfunction

    task automatic drive_vga(input bit en, input int n);
        vexp_t e;
        vga_req = en;
        if (en) begin
            vga_addr = 15'(n * 613 + 77 + cyc * 5);
            e.due    = cyc + 2;
            e.d      = vga_addr[7:0];
            vq.push_back(e);
        end
    endtask

    // Called just after the active edge of the request cycle T.
    task automatic run_quad(input int x, input int y,
                            input logic [14:0] a0, input logic [14:0] a1,
                            input logic [14:0] a2, input logic [14:0] a3,
                            input logic [15:0] mask, input bit hold);
        logic [14:0] a[4];
        logic [31:0] pk;
        qexp_t       e;
        int          t;
        int          idx;
        int          last;
        bit          exp_busy;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        pk   = {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
        t    = cyc;
        idx  = 0;
        last = -100;
        quad_req = 1'b1;
        quad_x   = 8'(x);
        quad_y   = 7'(y);
        drive_vga(mask[0], t);
        @(negedge clk);
        chk("ack_T", 32'(quad_ack), 32'd1);
        chk("busy_T", 32'(busy), 32'd0);
        if (mask[0]) chk("rom_addr_vga_T", 32'(rom_addr), 32'(vga_addr));
        else         chk("rom_addr_idle_T", 32'(rom_addr), 32'd0);
        for (int k = 1; k < 24; k++) begin
            tick();
            if (!hold) quad_req = 1'b0;
            drive_vga((k < 16) ? mask[k] : 1'b0, t + k);
            @(negedge clk);
            if (vga_req) begin
                chk("rom_addr_vga", 32'(rom_addr), 32'(vga_addr));
            end else if (idx < 4) begin
                chk($sformatf("rom_addr_p%0d", idx), 32'(rom_addr), 32'(a[idx]));
                idx++;
                if (idx == 4) begin
                    last  = k;
                    e.due = t + k + 2;
                    e.p   = pk;
                    qq.push_back(e);
                end
            end else begin
                chk("rom_addr_none", 32'(rom_addr), 32'd0);
            end
            exp_busy = (idx < 4) || (k <= last + 2);
            chk("busy", 32'(busy), 32'(exp_busy));
            if (k == last + 3) begin
                if (hold) begin
                    chk("reack_T7", 32'(quad_ack), 32'd1);
                    e.due = cyc + 6;
                    e.p   = pk;
                    qq.push_back(e);
                end else begin
                    chk("ack_idle", 32'(quad_ack), 32'd0);
                end
                break;
            end else begin
                chk("no_ack_busy", 32'(quad_ack), 32'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset && mon_en) begin
            if (vq.size() > 0 && vq[0].due == cyc) begin
                chk("vga_valid", 32'(vga_valid), 32'd1);
                chk("vga_data", 32'(vga_data), 32'(vq[0].d));
                void'(vq.pop_front());
            end else begin
                chk("vga_valid_idle", 32'(vga_valid), 32'd0);
            end
            if (qq.size() > 0 && qq[0].due == cyc) begin
                chk("quad_valid", 32'(quad_valid), 32'd1);
                chk("quad_p0", 32'(quad_p0), 32'(qq[0].p[7:0]));
                chk("quad_p1", 32'(quad_p1), 32'(qq[0].p[15:8]));
                chk("quad_p2", 32'(quad_p2), 32'(qq[0].p[23:16]));
                chk("quad_p3", 32'(quad_p3), 32'(qq[0].p[31:24]));
                void'(qq.pop_front());
            end else begin
                chk("quad_valid_idle", 32'(quad_valid), 32'd0);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_rom_addr"},   32'(rom_addr),   32'd0);
        chk({tag, "_quad_ack"},   32'(quad_ack),   32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_quad_valid"}, 32'(quad_valid), 32'd0);
        chk({tag, "_vga_valid"},  32'(vga_valid),  32'd0);
        chk({tag, "_vga_data"},   32'(vga_data),   32'd0);
        chk({tag, "_p"}, {quad_p3, quad_p2, quad_p1, quad_p0}, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            quad_req = 1'b0;
            vga_req  = 1'b0;
        end
    endtask

    initial begin
        reset    = 1'b1;
        vga_req  = 1'b1;
        vga_addr = 15'h1234;
        quad_req = 1'b1;
        quad_x   = 8'd3;
        quad_y   = 7'd3;
        tick();
        tick();
        @(negedge clk);
        check_reset_state("por");

        tick();
        reset    = 1'b0;
        vga_req  = 1'b0;
        quad_req = 1'b0;
        mon_en   = 1'b1;
        idle(2);

        // Quad alone
        tick();
        run_quad(5, 2, 15'd325, 15'd326, 15'd485, 15'd486, 16'h0000, 1'b0);
        idle(3);

        // VGA on alternate cycles through the fetch
        tick();
        run_quad(10, 3, nb(10, 3, 0), nb(10, 3, 1), nb(10, 3, 2), nb(10, 3, 3), 16'h5555, 1'b0);
        idle(4);

        // VGA only after the issue window: no delay expected
        tick();
        run_quad(40, 50, nb(40, 50, 0), nb(40, 50, 1), nb(40, 50, 2), nb(40, 50, 3), 16'h00E0, 1'b0);
        idle(4);

        // Request held through a whole fetch
        tick();
        run_quad(1, 1, nb(1, 1, 0), nb(1, 1, 1), nb(1, 1, 2), nb(1, 1, 3), 16'h0000, 1'b1);
        idle(9);

        // Bottom-right corner
        tick();
`ifdef QUAD_EDGE_CLAMP_EN
        run_quad(159, 119, 15'd19199, 15'd19199, 15'd19199, 15'd19199, 16'h0000, 1'b0);
`else
        run_quad(159, 119, 15'd19199, 15'd19200, 15'd19359, 15'd19360, 16'h0000, 1'b0);
`endif
        idle(3);

        // Reset in the middle of a fetch
        tick();
        quad_req = 1'b1;
        quad_x   = 8'd20;
        quad_y   = 7'd10;
        @(negedge clk);
        chk("mid_ack_T", 32'(quad_ack), 32'd1);
        tick();
        quad_req = 1'b0;
        tick();
        drive_vga(1'b1, 99);
        tick();
        vga_req  = 1'b0;
        quad_req = 1'b1;
        reset    = 1'b1;
        mon_en   = 1'b0;
        vq.delete();
        qq.delete();
        @(negedge clk);
        check_reset_state("mid");
        tick();
        @(negedge clk);
        chk("mid_vga_valid_T4", 32'(vga_valid), 32'd0);
        chk("mid_busy_T4", 32'(busy), 32'd0);
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        run_quad(7, 9, nb(7, 9, 0), nb(7, 9, 1), nb(7, 9, 2), nb(7, 9, 3), 16'h0000, 1'b0);
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
